gamecube_command_assembler: RTL

GAMECUBE_COMMAND_ASSEMBLER -- requirements
Module: gamecube_command_assembler

---
 rtl/gamecube_pkg.sv | 32 +++
 rtl/gamecube_idle_timer.sv | 44 ++++
 rtl/gamecube_command_assembler.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gamecube_pkg.sv
// Shared constants for the GameCube controller command path.
// Opcodes, frame lengths and the FSM state type.
package gamecube_pkg;

    localparam logic [7:0] OP_ID        = 8'h00;
    localparam logic [7:0] OP_STATUS    = 8'h40;
    localparam logic [7:0] OP_ORIGIN    = 8'h41;
    localparam logic [7:0] OP_CALIBRATE = 8'h42;
    localparam logic [7:0] OP_RESET     = 8'hFF;

    localparam int SHORT_FRAME_BITS     = 9;
    localparam int LONG_FRAME_BITS      = 25;
    localparam int DEFAULT_IDLE_TIMEOUT = 8;

    localparam int CMD_W   = 24;
    localparam int SHIFT_W = 25;
    localparam int CNT_W   = 5;

    typedef enum logic {
        ST_IDLE,
        ST_RECEIVING
    } asm_state_e;

    function automatic logic is_short(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(SHORT_FRAME_BITS);
    endfunction

    function automatic logic is_long(input logic [CNT_W-1:0] cnt);
        return cnt == CNT_W'(LONG_FRAME_BITS);
    endfunction

endpackage

// File: rtl/gamecube_idle_timer.sv
// Counts consecutive idle cycles of the serial line.
// Strobes on the cycle whose edge brings the count to IDLE_TIMEOUT.
module gamecube_idle_timer
    import gamecube_pkg::*;
#(
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic dataline_i,
    input  logic valid_data_i,
    input  logic enable_i,
    output logic timeout_o
);

    localparam int CW = $clog2(IDLE_TIMEOUT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          idle_c;

    assign idle_c = enable_i && dataline_i && !valid_data_i;

    always_comb begin
        cnt_d     = '0;
        timeout_o = 1'b0;
        if (idle_c) begin
            if (cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
                timeout_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gamecube_command_assembler.sv
// Assembles decoded bits into 1- or 3-byte commands.
// Frames end on line idle; output uses a valid/ready hold.
module gamecube_command_assembler
    import gamecube_pkg::*;
#(
    parameter int IDLE_TIMEOUT = DEFAULT_IDLE_TIMEOUT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             DATALINE,
    input  logic             RX,
    input  logic             VALID_DATA,
    input  logic             CMD_READY,
    output logic [CMD_W-1:0] CMD,
    output logic [1:0]       CMD_LEN,
    output logic             CMD_VALID,
    output logic             CMD_ERROR,
    output logic             CMD_OVERRUN
);

    asm_state_e         state_q, state_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic [1:0]         len_q, len_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;

    logic timeout;
    logic accept;
    logic good;
    logic rx_en;

    assign rx_en  = (state_q == ST_RECEIVING);
    assign accept = valid_q && CMD_READY;
    assign good   = (is_short(bitcnt_q) || is_long(bitcnt_q))
                    && shift_q[0];

    gamecube_idle_timer #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_idle_timer (
        .clk_i       (CLK),
        .rst_i       (RST),
        .dataline_i  (DATALINE),
        .valid_data_i(VALID_DATA),
        .enable_i    (rx_en),
        .timeout_o   (timeout)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        cmd_d    = cmd_q;
        len_d    = len_q;
        valid_d  = valid_q && !accept;
        err_d    = 1'b0;
        ovr_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (VALID_DATA) begin
                    shift_d  = {shift_q[SHIFT_W-2:0], RX};
                    bitcnt_d = bitcnt_q + 1'b1;
                    state_d  = ST_RECEIVING;
                end
            end
            ST_RECEIVING: begin
                if (VALID_DATA) begin
                    shift_d = {shift_q[SHIFT_W-2:0], RX};
                    if (bitcnt_q != '1) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end else if (timeout) begin
                    state_d  = ST_IDLE;
                    shift_d  = '0;
                    bitcnt_d = '0;
                    if (!good) begin
                        err_d = 1'b1;
                    end else if (valid_q && !accept) begin
                        ovr_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        if (is_short(bitcnt_q)) begin
                            cmd_d = {shift_q[8:1], 16'h0000};
                            len_d = 2'd1;
                        end else begin
                            cmd_d = shift_q[SHIFT_W-1:1];
                            len_d = 2'd3;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            bitcnt_q <= '0;
            cmd_q    <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            cmd_q    <= cmd_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            ovr_q    <= ovr_d;
        end
    end

    assign CMD         = cmd_q;
    assign CMD_LEN     = len_q;
    assign CMD_VALID   = valid_q;
    assign CMD_ERROR   = err_q;
    assign CMD_OVERRUN = ovr_q;

endmodule
